// File: rtl/fw_cmd_responder.sv
// Firmware-side endpoint of the SW-to-FW command register protocol for one device slot.
// Decodes the one-hot op strobes, runs config/data accesses and the execute handshake, reports status.
module fw_cmd_responder #(
   parameter int ARRAY_DEPTH  = 64,
   parameter int EXEC_TIMEOUT = 1024
) (
   input  logic        fw_axi_clk,
   input  logic        fw_rst,
   input  logic        fw_dev_id_enable,
   input  logic        fw_op_code_w_reset,
   input  logic        fw_op_code_w_cfg_static_0,
   input  logic        fw_op_code_r_cfg_static_0,
   input  logic        fw_op_code_w_cfg_array_0,
   input  logic        fw_op_code_r_cfg_array_0,
   input  logic        fw_op_code_w_cfg_array_1,
   input  logic        fw_op_code_r_cfg_array_1,
   input  logic        fw_op_code_r_data_array_0,
   input  logic        fw_op_code_r_data_array_1,
   input  logic        fw_op_code_w_status_clear,
   input  logic        fw_op_code_w_execute,
   input  logic [23:0] sw_write24_0,
   output logic [31:0] fw_read_data32,
   output logic [31:0] fw_read_status32,
   output logic [23:0] cfg_static_0,
   input  logic [7:0]  core_cfg_addr,
   output logic [15:0] core_cfg_data,
   input  logic        data_wr_en,
   input  logic [7:0]  data_wr_addr,
   input  logic [31:0] data_wr_data,
   output logic        exec_start,
   input  logic        exec_done,
   output logic        fw_soft_reset
);

   localparam int AW = (ARRAY_DEPTH > 1) ? $clog2(ARRAY_DEPTH) : 1;
   localparam int CW = $clog2(EXEC_TIMEOUT + 1);
   localparam logic [8:0]    DEPTH_LIM = 9'(ARRAY_DEPTH);
   localparam logic [CW-1:0] TMO_LAST  = CW'(EXEC_TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_RD_WAIT   = 2'd1;
   localparam logic [1:0] ST_EXEC_WAIT = 2'd2;

   localparam logic [3:0] OP_W_RESET        = 4'd1;
   localparam logic [3:0] OP_W_CFG_STATIC_0 = 4'd2;
   localparam logic [3:0] OP_R_CFG_STATIC_0 = 4'd3;
   localparam logic [3:0] OP_W_CFG_ARRAY_0  = 4'd4;
   localparam logic [3:0] OP_R_CFG_ARRAY_0  = 4'd5;
   localparam logic [3:0] OP_R_DATA_ARRAY_0 = 4'd8;
   localparam logic [3:0] OP_W_STATUS_CLEAR = 4'd10;
   localparam logic [3:0] OP_W_EXECUTE      = 4'd11;

   logic [1:0]    state;
   logic          any_op_q;
   logic          cmd_done, err_unsup, err_addr, err_busy, err_timeout, exec_ok;
   logic [7:0]    cmd_count;
   logic [3:0]    last_op;
   logic [CW-1:0] exec_cnt;
   logic [31:0]   rd_latch;

   logic [15:0] cfg_mem  [ARRAY_DEPTH];
   logic [31:0] data_mem [ARRAY_DEPTH];

   // Bit i of the strobe vector corresponds to op code i+1.
   logic [10:0] strobes;
   assign strobes = {fw_op_code_w_execute, fw_op_code_w_status_clear, fw_op_code_r_data_array_1,
                     fw_op_code_r_data_array_0, fw_op_code_r_cfg_array_1, fw_op_code_w_cfg_array_1,
                     fw_op_code_r_cfg_array_0, fw_op_code_w_cfg_array_0, fw_op_code_r_cfg_static_0,
                     fw_op_code_w_cfg_static_0, fw_op_code_w_reset};

   logic [3:0] op_enc;
   // NOTE: op_enc gets a default before the loop so the block never infers a latch.
   always_comb begin
      op_enc = 4'd0;
      for (int i = 0; i < 11; i++) begin
         if (strobes[i]) op_enc = 4'(i + 1);
      end
   end

   logic       any_op, sel_op, accept, multi_op, soft_rst, idle_cmd;
   logic [7:0] sw_addr;
   logic       sw_addr_ok, core_wr_ok, cfg_wr_en, rd_start;

   assign any_op     = |strobes;
   assign sel_op     = fw_dev_id_enable & any_op;
   assign accept     = sel_op & ~any_op_q;
   assign multi_op   = |(strobes & (strobes - 11'd1));
   assign soft_rst   = accept & ~multi_op & (op_enc == OP_W_RESET);
   assign idle_cmd   = accept & ~multi_op & (state == ST_IDLE) & ~soft_rst;
   assign sw_addr    = sw_write24_0[23:16];
   assign sw_addr_ok = ({1'b0, sw_addr} < DEPTH_LIM);
   assign core_wr_ok = data_wr_en & ({1'b0, data_wr_addr} < DEPTH_LIM);
   assign cfg_wr_en  = idle_cmd & (op_enc == OP_W_CFG_ARRAY_0) & sw_addr_ok;
   assign rd_start   = idle_cmd & ((op_enc == OP_R_CFG_STATIC_0) | (op_enc == OP_R_CFG_ARRAY_0) |
                                   (op_enc == OP_R_DATA_ARRAY_0));

   // NOTE: the arrays and rd_latch carry no reset so they can map onto RAM; rd_latch is only
   // consumed in the cycle after a read accept, so its power-up value never reaches an output.
   always_ff @(posedge fw_axi_clk) begin
      if (cfg_wr_en) cfg_mem[sw_addr[AW-1:0]] <= sw_write24_0[15:0];
      if (core_wr_ok) data_mem[data_wr_addr[AW-1:0]] <= data_wr_data;
      if (rd_start) begin
         if (op_enc == OP_R_CFG_STATIC_0)     rd_latch <= {8'h0, cfg_static_0};
         else if (!sw_addr_ok)                rd_latch <= '0;
         else if (op_enc == OP_R_CFG_ARRAY_0) rd_latch <= {16'h0, cfg_mem[sw_addr[AW-1:0]]};
         else                                 rd_latch <= data_mem[sw_addr[AW-1:0]];
      end
   end

   always_ff @(posedge fw_axi_clk) begin
      if (fw_rst)                                      core_cfg_data <= '0;
      else if ({1'b0, core_cfg_addr} < DEPTH_LIM)      core_cfg_data <= cfg_mem[core_cfg_addr[AW-1:0]];
      else                                             core_cfg_data <= '0;
   end

   // NOTE: state uses non-blocking assignments only; a later assignment in the same edge wins,
   // which is how status clear overrides the generic cmd_count increment.
   always_ff @(posedge fw_axi_clk) begin
      if (fw_rst) begin
         state          <= ST_IDLE;
         any_op_q       <= 1'b0;
         cfg_static_0   <= '0;
         fw_read_data32 <= '0;
         cmd_done       <= 1'b0;
         err_unsup      <= 1'b0;
         err_addr       <= 1'b0;
         err_busy       <= 1'b0;
         err_timeout    <= 1'b0;
         exec_ok        <= 1'b0;
         cmd_count      <= '0;
         last_op        <= '0;
         exec_cnt       <= '0;
         exec_start     <= 1'b0;
         fw_soft_reset  <= 1'b0;
      end else begin
         any_op_q      <= sel_op;
         exec_start    <= 1'b0;
         fw_soft_reset <= 1'b0;
         if (soft_rst) begin
            state          <= ST_IDLE;
            cfg_static_0   <= '0;
            fw_read_data32 <= '0;
            cmd_done       <= 1'b0;
            err_unsup      <= 1'b0;
            err_addr       <= 1'b0;
            err_busy       <= 1'b0;
            err_timeout    <= 1'b0;
            exec_ok        <= 1'b0;
            cmd_count      <= '0;
            last_op        <= '0;
            exec_cnt       <= '0;
            fw_soft_reset  <= 1'b1;
         end else begin
            case (state)
               ST_RD_WAIT: begin
                  fw_read_data32 <= rd_latch;
                  cmd_done       <= 1'b1;
                  state          <= ST_IDLE;
               end
               ST_EXEC_WAIT: begin
                  exec_cnt <= exec_cnt + 1'b1;
                  if (exec_done) begin
                     exec_ok  <= 1'b1;
                     cmd_done <= 1'b1;
                     state    <= ST_IDLE;
                  end else if (exec_cnt == TMO_LAST) begin
                     err_timeout <= 1'b1;
                     cmd_done    <= 1'b1;
                     state       <= ST_IDLE;
                  end
               end
               default: ;
            endcase

            if (accept) begin
               cmd_count <= cmd_count + 8'd1;
               if (multi_op) begin
                  err_unsup <= 1'b1;
               end else begin
                  last_op <= op_enc;
                  if (state != ST_IDLE) begin
                     err_busy <= 1'b1;
                  end else begin
                     case (op_enc)
                        OP_W_CFG_STATIC_0: begin
                           cfg_static_0 <= sw_write24_0;
                           cmd_done     <= 1'b1;
                        end
                        OP_W_CFG_ARRAY_0: begin
                           if (!sw_addr_ok) err_addr <= 1'b1;
                           cmd_done <= 1'b1;
                        end
                        OP_R_CFG_STATIC_0: state <= ST_RD_WAIT;
                        OP_R_CFG_ARRAY_0, OP_R_DATA_ARRAY_0: begin
                           if (!sw_addr_ok) err_addr <= 1'b1;
                           state <= ST_RD_WAIT;
                        end
                        OP_W_STATUS_CLEAR: begin
                           err_unsup   <= 1'b0;
                           err_addr    <= 1'b0;
                           err_busy    <= 1'b0;
                           err_timeout <= 1'b0;
                           exec_ok     <= 1'b0;
                           cmd_count   <= 8'd1;
                           cmd_done    <= 1'b1;
                        end
                        OP_W_EXECUTE: begin
                           state      <= ST_EXEC_WAIT;
                           exec_start <= 1'b1;
                           exec_cnt   <= '0;
                        end
                        default: err_unsup <= 1'b1;
                     endcase
                  end
               end
            end
         end
      end
   end

   assign fw_read_status32 = {12'h0, last_op, cmd_count, 1'b0, exec_ok, err_timeout, err_busy,
                              err_addr, err_unsup, cmd_done, (state != ST_IDLE)};

endmodule

// File: tb/tb_fw_cmd_responder.sv
// Self-checking bench for fw_cmd_responder: randomized commands checked against a
// transaction-level model of the command protocol kept in this file.
module tb_fw_cmd_responder;

   localparam int DEPTH = 64;
   localparam int TMO   = 1024;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        fw_rst;
   logic        enable;
   logic [10:0] op_vec;
   logic [23:0] body;
   logic [31:0] rd_data;
   logic [31:0] status;
   logic [23:0] cfg_static;
   logic [7:0]  core_cfg_addr;
   logic [15:0] core_cfg_data;
   logic        data_wr_en;
   logic [7:0]  data_wr_addr;
   logic [31:0] data_wr_data;
   logic        exec_start;
   logic        exec_done;
   logic        soft_reset;

   fw_cmd_responder #(.ARRAY_DEPTH(DEPTH), .EXEC_TIMEOUT(TMO)) dut (
      .fw_axi_clk                (clk),
      .fw_rst                    (fw_rst),
      .fw_dev_id_enable          (enable),
      .fw_op_code_w_reset        (op_vec[0]),
      .fw_op_code_w_cfg_static_0 (op_vec[1]),
      .fw_op_code_r_cfg_static_0 (op_vec[2]),
      .fw_op_code_w_cfg_array_0  (op_vec[3]),
      .fw_op_code_r_cfg_array_0  (op_vec[4]),
      .fw_op_code_w_cfg_array_1  (op_vec[5]),
      .fw_op_code_r_cfg_array_1  (op_vec[6]),
      .fw_op_code_r_data_array_0 (op_vec[7]),
      .fw_op_code_r_data_array_1 (op_vec[8]),
      .fw_op_code_w_status_clear (op_vec[9]),
      .fw_op_code_w_execute      (op_vec[10]),
      .sw_write24_0              (body),
      .fw_read_data32            (rd_data),
      .fw_read_status32          (status),
      .cfg_static_0              (cfg_static),
      .core_cfg_addr             (core_cfg_addr),
      .core_cfg_data             (core_cfg_data),
      .data_wr_en                (data_wr_en),
      .data_wr_addr              (data_wr_addr),
      .data_wr_data              (data_wr_data),
      .exec_start                (exec_start),
      .exec_done                 (exec_done),
      .fw_soft_reset             (soft_reset)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model of what SW should observe.
   logic [23:0] m_static;
   logic [15:0] m_cfg  [256];
   logic [31:0] m_data [256];
   logic        m_done, m_unsup, m_addr, m_busy, m_tmo, m_ok;
   logic [7:0]  m_count;
   logic [3:0]  m_last;
   logic [31:0] m_rd, m_rd_next;

   function automatic logic [31:0] exp_status(input logic busy);
      return {12'h0, m_last, m_count, 1'b0, m_ok, m_tmo, m_busy, m_addr, m_unsup, m_done, busy};
   endfunction

   task automatic model_clear();
      m_static = '0; m_rd = '0; m_rd_next = '0;
      m_done = 0; m_unsup = 0; m_addr = 0; m_busy = 0; m_tmo = 0; m_ok = 0;
      m_count = '0; m_last = '0;
   endtask

   // Effect of one accepted single-strobe command issued while idle.
   task automatic model_cmd(input int op, input logic [23:0] b);
      logic [7:0] a;
      logic       ok;
      a  = b[23:16];
      ok = (int'(a) < DEPTH);
      m_count = m_count + 8'd1;
      m_last  = 4'(op);
      case (op)
         1:  model_clear();
         2:  begin m_static = b; m_done = 1; end
         3:  begin m_rd_next = {8'h0, m_static}; m_done = 1; end
         4:  begin if (ok) m_cfg[a] = b[15:0]; else m_addr = 1; m_done = 1; end
         5:  begin m_rd_next = ok ? {16'h0, m_cfg[a]} : 32'h0; if (!ok) m_addr = 1; m_done = 1; end
         8:  begin m_rd_next = ok ? m_data[a] : 32'h0; if (!ok) m_addr = 1; m_done = 1; end
         6, 7, 9: m_unsup = 1;
         10: begin m_unsup = 0; m_addr = 0; m_busy = 0; m_tmo = 0; m_ok = 0; m_count = 8'd1; m_done = 1; end
         default: ;
      endcase
   endtask

   task automatic model_busy(input int op);
      m_count = m_count + 8'd1;
      m_last  = 4'(op);
      m_busy  = 1;
   endtask

   task automatic drive_op(input int op, input logic [23:0] b);
      @(negedge clk);
      op_vec = '0; op_vec[op-1] = 1'b1; body = b; enable = 1'b1;
      @(negedge clk);
      op_vec = '0;
   endtask

   task automatic do_cmd(input int op, input logic [23:0] b);
      drive_op(op, b);
      model_cmd(op, b);
   endtask

   task automatic wait_rd();
      @(negedge clk);
      m_rd = m_rd_next;
   endtask

   task automatic core_write(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      data_wr_en = 1'b1; data_wr_addr = a; data_wr_data = d;
      @(negedge clk);
      data_wr_en = 1'b0;
      if (int'(a) < DEPTH) m_data[a] = d;
   endtask

   task automatic test_reset();
      fw_rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (status !== 32'h0) begin n_errors++; $display("FAIL reset_status: got %h exp 0", status); end
      n_checks++; if (rd_data !== 32'h0) begin n_errors++; $display("FAIL reset_rd: got %h exp 0", rd_data); end
      n_checks++; if (cfg_static !== 24'h0) begin n_errors++; $display("FAIL reset_static: got %h exp 0", cfg_static); end
      n_checks++; if ({exec_start, soft_reset} !== 2'b00) begin n_errors++; $display("FAIL reset_pulses: got %b exp 00", {exec_start, soft_reset}); end
      n_checks++; if (core_cfg_data !== 16'h0) begin n_errors++; $display("FAIL reset_core_cfg: got %h exp 0", core_cfg_data); end
      fw_rst = 1'b0;
      model_clear();
   endtask

   task automatic test_static();
      logic [23:0] b;
      do_cmd(2, 24'h00A5C3);
      n_checks++; if (cfg_static !== m_static) begin n_errors++; $display("FAIL static_wr: got %h exp %h", cfg_static, m_static); end
      do_cmd(3, 24'($urandom));
      n_checks++; if (rd_data !== m_rd) begin n_errors++; $display("FAIL static_rd_early: got %h exp %h", rd_data, m_rd); end
      wait_rd();
      n_checks++; if (rd_data !== m_rd) begin n_errors++; $display("FAIL static_rd: got %h exp %h", rd_data, m_rd); end
      n_checks++; if (status !== exp_status(1'b0)) begin n_errors++; $display("FAIL static_status: got %h exp %h", status, exp_status(1'b0)); end
      for (int i = 0; i < 4; i++) begin
         b = 24'($urandom);
         do_cmd(2, b);
         do_cmd(3, 24'($urandom));
         wait_rd();
         n_checks++; if (rd_data !== m_rd) begin n_errors++; $display("FAIL static_rand_rd[%0d]: got %h exp %h", i, rd_data, m_rd); end
      end
   endtask

   task automatic test_cfg_array();
      logic [7:0]  a;
      logic [7:0]  written[$];
      do_cmd(4, {8'd5, 16'hBEEF});
      written.push_back(8'd5);
      core_cfg_addr = 8'd5;
      @(negedge clk);
      n_checks++; if (core_cfg_data !== m_cfg[5]) begin n_errors++; $display("FAIL core_cfg_5: got %h exp %h", core_cfg_data, m_cfg[5]); end
      do_cmd(5, {8'd64, 16'h0});
      wait_rd();
      n_checks++; if (rd_data !== m_rd) begin n_errors++; $display("FAIL cfg_rd_oob: got %h exp %h", rd_data, m_rd); end
      n_checks++; if (status !== exp_status(1'b0)) begin n_errors++; $display("FAIL cfg_oob_status: got %h exp %h", status, exp_status(1'b0)); end
      do_cmd(4, {8'd63, 16'($urandom)});
      written.push_back(8'd63);
      for (int i = 0; i < 8; i++) begin
         a = 8'($urandom_range(0, DEPTH - 1));
         do_cmd(4, {a, 16'($urandom)});
         written.push_back(a);
      end
      for (int i = 0; i < 8; i++) begin
         a = written[$urandom_range(0, written.size() - 1)];
         do_cmd(5, {a, 16'($urandom)});
         wait_rd();
         n_checks++; if (rd_data !== m_rd) begin n_errors++; $display("FAIL cfg_rd[%0d] addr %0d: got %h exp %h", i, a, rd_data, m_rd); end
         core_cfg_addr = a;
         @(negedge clk);
         n_checks++; if (core_cfg_data !== m_cfg[a]) begin n_errors++; $display("FAIL core_cfg[%0d] addr %0d: got %h exp %h", i, a, core_cfg_data, m_cfg[a]); end
      end
   endtask

   task automatic test_hold();
      logic [23:0] b;
      b = 24'($urandom);
      @(negedge clk);
      op_vec = '0; op_vec[1] = 1'b1; body = b; enable = 1'b1;
      repeat (10) @(negedge clk);
      op_vec = '0;
      model_cmd(2, b);
      @(negedge clk);
      n_checks++; if (status !== exp_status(1'b0)) begin n_errors++; $display("FAIL hold_once: got %h exp %h", status, exp_status(1'b0)); end
      enable = 1'b0; op_vec[1] = 1'b1; body = ~b;
      repeat (10) @(negedge clk);
      op_vec = '0; enable = 1'b1;
      @(negedge clk);
      n_checks++; if (status !== exp_status(1'b0)) begin n_errors++; $display("FAIL hold_disabled: got %h exp %h", status, exp_status(1'b0)); end
      n_checks++; if (cfg_static !== m_static) begin n_errors++; $display("FAIL hold_disabled_static: got %h exp %h", cfg_static, m_static); end
      b = 24'($urandom);
      op_vec[1] = 1'b1; body = b;
      repeat (3) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      repeat (3) @(negedge clk);
      op_vec = '0;
      model_cmd(2, b);
      model_cmd(2, b);
      @(negedge clk);
      n_checks++; if (status !== exp_status(1'b0)) begin n_errors++; $display("FAIL hold_reenable: got %h exp %h", status, exp_status(1'b0)); end
   endtask

   task automatic test_execute();
      int starts;
      int busy_n;
      int cyc;
      do_cmd(11, 24'($urandom));
      starts = 0; busy_n = 0;
      for (int i = 0; i < 20; i++) begin
         if (exec_start === 1'b1) starts++;
         if (status[0] === 1'b1) busy_n++;
         @(negedge clk);
      end
      exec_done = 1'b1;
      @(negedge clk);
      exec_done = 1'b0;
      if (exec_start === 1'b1) starts++;
      m_ok = 1; m_done = 1;
      n_checks++; if (starts !== 1) begin n_errors++; $display("FAIL exec_start_pulses: got %0d exp 1", starts); end
      n_checks++; if (busy_n !== 20) begin n_errors++; $display("FAIL exec_busy_cycles: got %0d exp 20", busy_n); end
      n_checks++; if (status !== exp_status(1'b0)) begin n_errors++; $display("FAIL exec_ok_status: got %h exp %h", status, exp_status(1'b0)); end
      do_cmd(11, 24'($urandom));
      cyc = 0;
      while (status[0] === 1'b1 && cyc < 2 * TMO) begin
         @(negedge clk);
         cyc++;
      end
      m_tmo = 1; m_done = 1;
      n_checks++; if (cyc !== TMO) begin n_errors++; $display("FAIL exec_timeout_cycles: got %0d exp %0d", cyc, TMO); end
      n_checks++; if (status !== exp_status(1'b0)) begin n_errors++; $display("FAIL exec_timeout_status: got %h exp %h", status, exp_status(1'b0)); end
   endtask

   task automatic test_busy_soft_reset();
      do_cmd(11, 24'($urandom));
      drive_op(2, 24'h777777);
      model_busy(2);
      n_checks++; if (cfg_static !== m_static) begin n_errors++; $display("FAIL busy_static: got %h exp %h", cfg_static, m_static); end
      n_checks++; if (status !== exp_status(1'b1)) begin n_errors++; $display("FAIL busy_status: got %h exp %h", status, exp_status(1'b1)); end
      drive_op(8, 24'h030000);
      model_busy(8);
      @(negedge clk);
      n_checks++; if (rd_data !== m_rd) begin n_errors++; $display("FAIL busy_rd: got %h exp %h", rd_data, m_rd); end
      drive_op(1, 24'($urandom));
      model_cmd(1, 24'h0);
      n_checks++; if (soft_reset !== 1'b1) begin n_errors++; $display("FAIL soft_reset_high: got %b exp 1", soft_reset); end
      n_checks++; if (status !== exp_status(1'b0)) begin n_errors++; $display("FAIL soft_reset_status: got %h exp %h", status, exp_status(1'b0)); end
      n_checks++; if ({cfg_static, rd_data} !== {m_static, m_rd}) begin n_errors++; $display("FAIL soft_reset_regs: got %h/%h exp %h/%h", cfg_static, rd_data, m_static, m_rd); end
      @(negedge clk);
      n_checks++; if ({soft_reset, exec_start} !== 2'b00) begin n_errors++; $display("FAIL soft_reset_low: got %b exp 00", {soft_reset, exec_start}); end
      exec_done = 1'b1;
      @(negedge clk);
      exec_done = 1'b0;
      @(negedge clk);
      n_checks++; if (status !== exp_status(1'b0)) begin n_errors++; $display("FAIL stray_done_status: got %h exp %h", status, exp_status(1'b0)); end
   endtask

   task automatic test_data_array();
      logic [7:0]  a;
      core_write(8'd3, 32'h12345678);
      do_cmd(8, {8'd3, 16'h0});
      n_checks++; if (rd_data !== m_rd) begin n_errors++; $display("FAIL data_rd_early: got %h exp %h", rd_data, m_rd); end
      wait_rd();
      n_checks++; if (rd_data !== m_rd) begin n_errors++; $display("FAIL data_rd_3: got %h exp %h", rd_data, m_rd); end
      core_write(8'd67, 32'hDEADBEEF);
      do_cmd(8, {8'd3, 16'h0});
      wait_rd();
      n_checks++; if (rd_data !== m_rd) begin n_errors++; $display("FAIL data_oob_write_dropped: got %h exp %h", rd_data, m_rd); end
      for (int i = 0; i < 6; i++) begin
         a = 8'($urandom_range(4, DEPTH - 1));
         core_write(a, $urandom);
         do_cmd(8, {a, 16'($urandom)});
         wait_rd();
         n_checks++; if (rd_data !== m_rd) begin n_errors++; $display("FAIL data_rd[%0d] addr %0d: got %h exp %h", i, a, rd_data, m_rd); end
      end
      @(negedge clk);
      op_vec = '0; op_vec[7] = 1'b1; body = {8'd3, 16'h0}; enable = 1'b1;
      data_wr_en = 1'b1; data_wr_addr = 8'd3; data_wr_data = 32'hCAFEF00D;
      @(negedge clk);
      op_vec = '0; data_wr_en = 1'b0;
      model_cmd(8, {8'd3, 16'h0});
      m_data[3] = 32'hCAFEF00D;
      wait_rd();
      n_checks++; if (rd_data !== m_rd) begin n_errors++; $display("FAIL data_read_first: got %h exp %h", rd_data, m_rd); end
      do_cmd(8, {8'd3, 16'h0});
      wait_rd();
      n_checks++; if (rd_data !== m_rd) begin n_errors++; $display("FAIL data_after_collision: got %h exp %h", rd_data, m_rd); end
      a = 8'($urandom_range(DEPTH, 255));
      do_cmd(8, {a, 16'h0});
      wait_rd();
      n_checks++; if (rd_data !== m_rd) begin n_errors++; $display("FAIL data_rd_oob addr %0d: got %h exp %h", a, rd_data, m_rd); end
      n_checks++; if (status !== exp_status(1'b0)) begin n_errors++; $display("FAIL data_oob_status: got %h exp %h", status, exp_status(1'b0)); end
      do_cmd(9, 24'($urandom));
      n_checks++; if (status !== exp_status(1'b0)) begin n_errors++; $display("FAIL unsup_status: got %h exp %h", status, exp_status(1'b0)); end
      @(negedge clk);
      op_vec = 11'b000_0000_0110; body = 24'h5A5A5A; enable = 1'b1;
      @(negedge clk);
      op_vec = '0;
      m_count = m_count + 8'd1; m_unsup = 1;
      n_checks++; if (cfg_static !== m_static) begin n_errors++; $display("FAIL multi_static: got %h exp %h", cfg_static, m_static); end
      n_checks++; if (status !== exp_status(1'b0)) begin n_errors++; $display("FAIL multi_status: got %h exp %h", status, exp_status(1'b0)); end
   endtask

   task automatic test_status_clear();
      do_cmd(10, 24'($urandom));
      n_checks++; if (status !== exp_status(1'b0)) begin n_errors++; $display("FAIL clear_status: got %h exp %h", status, exp_status(1'b0)); end
      for (int i = 0; i < 260; i++) do_cmd(2, 24'($urandom));
      n_checks++; if (status !== exp_status(1'b0)) begin n_errors++; $display("FAIL count_wrap: got %h exp %h", status, exp_status(1'b0)); end
      n_checks++; if (cfg_static !== m_static) begin n_errors++; $display("FAIL wrap_static: got %h exp %h", cfg_static, m_static); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      fw_rst = 1'b1; enable = 1'b0; op_vec = '0; body = '0;
      core_cfg_addr = '0; data_wr_en = 1'b0; data_wr_addr = '0; data_wr_data = '0;
      exec_done = 1'b0;
      test_reset();
      test_static();
      test_cfg_array();
      test_hold();
      test_execute();
      test_busy_soft_reset();
      test_data_array();
      test_status_clear();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
